// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loadable instruction memory feeding the cpu fetch port
// Holds the cpu in reset while a new program image is streamed in byte by byte.
module imem_loader #(
  parameter int          DEPTH   = 32,
  parameter int          ADDR_W  = 5,
  parameter logic [7:0]  HALT_OP = 8'hC0
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  input  logic [7:0]        cpu_address,
  output logic [7:0]        instruction,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FILL  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_V  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_V   = (ADDR_W + 1)'(1);
  localparam logic [7:0]      DEPTH_A = 8'(DEPTH);

  state_t            state, state_n;
  logic [ADDR_W:0]   wr_ptr, wr_ptr_n;
  logic [ADDR_W:0]   len_q, len_n;
  logic              mem_we;
  logic [7:0]        mem_wd;
  logic [7:0]        mem [DEPTH];
  logic              hs;

  assign hs = load_valid && load_ready;

  // Memory lives in resettable flops so an aborted session never leaves a partial image.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      len_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= HALT_OP;
      end
    end else begin
      state  <= state_n;
      wr_ptr <= wr_ptr_n;
      len_q  <= len_n;
      if (mem_we) begin
        mem[wr_ptr[ADDR_W-1:0]] <= mem_wd;
      end
    end
  end

  always_comb begin
    state_n    = state;
    wr_ptr_n   = wr_ptr;
    len_n      = len_q;
    mem_we     = 1'b0;
    mem_wd     = HALT_OP;
    load_ready = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          state_n  = LOAD;
          wr_ptr_n = '0;
          len_n    = (load_len == '0 || load_len > DEPTH_V) ? DEPTH_V : load_len;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        if (hs) begin
          mem_we   = 1'b1;
          mem_wd   = load_data;
          wr_ptr_n = wr_ptr + ONE_V;
          if (wr_ptr == len_q - ONE_V) begin
            state_n = (len_q < DEPTH_V) ? FILL : FLUSH;
          end
        end
      end
      FILL: begin
        // Clear the tail so a shorter program never runs into stale bytes.
        mem_we   = 1'b1;
        mem_wd   = HALT_OP;
        wr_ptr_n = wr_ptr + ONE_V;
        if (wr_ptr == LAST_V) begin
          state_n = FLUSH;
        end
      end
      FLUSH: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign cpu_reset = reset | busy;

  // The cpu only ever sees a completed image; out-of-range fetches halt.
  assign instruction = (state == IDLE && cpu_address < DEPTH_A)
                       ? mem[cpu_address[ADDR_W-1:0]] : HALT_OP;

endmodule
